// File: rtl/nw_traceback.sv
// Needleman-Wunsch traceback: walks stored direction codes from the bottom-right
// cell back to the origin and streams the alignment out in reverse order.
module nw_traceback #(
    parameter int LENGTH = 10,
    parameter int CWIDTH = 2,
    parameter int IWIDTH = $clog2(LENGTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [LENGTH*CWIDTH-1:0]   s1,
    input  logic [LENGTH*CWIDTH-1:0]   s2,
    output logic                       dir_rd_en,
    output logic [IWIDTH-2:0]          dir_row,
    output logic [IWIDTH-2:0]          dir_col,
    input  logic [1:0]                 dir_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CWIDTH-1:0]          out_c1,
    output logic [CWIDTH-1:0]          out_c2,
    output logic                       out_gap1,
    output logic                       out_gap2,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [IWIDTH:0]            pair_count
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_EMIT, S_DONE} state_t;

    localparam logic signed [IWIDTH-1:0] IDX_LAST = IWIDTH'(LENGTH - 1);
    localparam logic signed [IWIDTH-1:0] IDX_ONE  = IWIDTH'(1);
    localparam logic        [IWIDTH:0]   PC_ONE   = (IWIDTH+1)'(1);

    state_t                     r_state;
    logic [LENGTH*CWIDTH-1:0]   r_s1;
    logic [LENGTH*CWIDTH-1:0]   r_s2;
    logic signed [IWIDTH-1:0]   r_j;
    logic signed [IWIDTH-1:0]   r_k;

    logic signed [IWIDTH-1:0]   w_nj;
    logic signed [IWIDTH-1:0]   w_nk;
    logic                       w_gap1;
    logic                       w_gap2;
    logic                       w_pair;
    logic                       w_rsv;
    logic                       w_last;
    logic [CWIDTH-1:0]          w_c1;
    logic [CWIDTH-1:0]          w_c2;

    function automatic logic [CWIDTH-1:0] char_at(input logic [LENGTH*CWIDTH-1:0] str,
                                                  input logic [IWIDTH-2:0] idx);
        logic [CWIDTH-1:0] c;
        c = {CWIDTH{1'b0}};
        for (int i = 0; i < LENGTH; i++) begin
            if (idx == (IWIDTH-1)'(i)) begin
                c = str[i*CWIDTH +: CWIDTH];
            end
        end
        return c;
    endfunction

    // Decode the next alignment column: boundary moves in READ, stored code in WAIT.
    always_comb begin
        w_nj   = r_j;
        w_nk   = r_k;
        w_gap1 = 1'b0;
        w_gap2 = 1'b0;
        w_pair = 1'b0;
        w_rsv  = 1'b0;
        if (r_state == S_READ) begin
            if (r_j[IWIDTH-1]) begin
                w_gap1 = 1'b1;
                w_nk   = r_k - IDX_ONE;
                w_pair = 1'b1;
            end else if (r_k[IWIDTH-1]) begin
                w_gap2 = 1'b1;
                w_nj   = r_j - IDX_ONE;
                w_pair = 1'b1;
            end else begin
                w_pair = 1'b0;
            end
        end else if (r_state == S_WAIT) begin
            case (dir_rdata)
                2'b00: begin
                    w_nj   = r_j - IDX_ONE;
                    w_nk   = r_k - IDX_ONE;
                    w_pair = 1'b1;
                end
                2'b01: begin
                    w_nj   = r_j - IDX_ONE;
                    w_gap2 = 1'b1;
                    w_pair = 1'b1;
                end
                2'b10: begin
                    w_nk   = r_k - IDX_ONE;
                    w_gap1 = 1'b1;
                    w_pair = 1'b1;
                end
                default: w_rsv = 1'b1;
            endcase
        end else begin
            w_pair = 1'b0;
        end
        // Gapped sides read a don't-care index, so force the character to zero.
        w_c1   = w_gap1 ? {CWIDTH{1'b0}} : char_at(r_s1, r_j[IWIDTH-2:0]);
        w_c2   = w_gap2 ? {CWIDTH{1'b0}} : char_at(r_s2, r_k[IWIDTH-2:0]);
        w_last = w_nj[IWIDTH-1] & w_nk[IWIDTH-1];
    end

    // Traceback sequencer with registered stream, read and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_s1       <= {(LENGTH*CWIDTH){1'b0}};
            r_s2       <= {(LENGTH*CWIDTH){1'b0}};
            r_j        <= {IWIDTH{1'b0}};
            r_k        <= {IWIDTH{1'b0}};
            dir_rd_en  <= 1'b0;
            dir_row    <= {(IWIDTH-1){1'b0}};
            dir_col    <= {(IWIDTH-1){1'b0}};
            out_valid  <= 1'b0;
            out_c1     <= {CWIDTH{1'b0}};
            out_c2     <= {CWIDTH{1'b0}};
            out_gap1   <= 1'b0;
            out_gap2   <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            pair_count <= {(IWIDTH+1){1'b0}};
        end else begin
            done      <= 1'b0;
            dir_rd_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_s1       <= s1;
                        r_s2       <= s2;
                        r_j        <= IDX_LAST;
                        r_k        <= IDX_LAST;
                        pair_count <= {(IWIDTH+1){1'b0}};
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        dir_rd_en  <= 1'b1;
                        dir_row    <= IDX_LAST[IWIDTH-2:0];
                        dir_col    <= IDX_LAST[IWIDTH-2:0];
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_pair) begin
                        out_valid <= 1'b1;
                        out_c1    <= w_c1;
                        out_c2    <= w_c2;
                        out_gap1  <= w_gap1;
                        out_gap2  <= w_gap2;
                        out_last  <= w_last;
                        r_j       <= w_nj;
                        r_k       <= w_nk;
                        r_state   <= S_EMIT;
                    end else begin
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_rsv) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        out_valid <= 1'b1;
                        out_c1    <= w_c1;
                        out_c2    <= w_c2;
                        out_gap1  <= w_gap1;
                        out_gap2  <= w_gap2;
                        out_last  <= w_last;
                        r_j       <= w_nj;
                        r_k       <= w_nk;
                        r_state   <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        out_last   <= 1'b0;
                        pair_count <= pair_count + PC_ONE;
                        if (r_j[IWIDTH-1] && r_k[IWIDTH-1]) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            // Only interior cells need the grid; boundary steps skip the read.
                            dir_rd_en <= ~r_j[IWIDTH-1] & ~r_k[IWIDTH-1];
                            dir_row   <= r_j[IWIDTH-2:0];
                            dir_col   <= r_k[IWIDTH-2:0];
                            r_state   <= S_READ;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nw_traceback.sv
// Table-driven scoreboard bench for nw_traceback with a behavioural direction memory.
module tb_nw_traceback;

    localparam int L  = 4;
    localparam int CW = 2;
    localparam int IW = $clog2(L) + 1;

    logic            clk;
    logic            reset;
    logic            start;
    logic [L*CW-1:0] s1;
    logic [L*CW-1:0] s2;
    logic            dir_rd_en;
    logic [IW-2:0]   dir_row;
    logic [IW-2:0]   dir_col;
    logic [1:0]      dir_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   out_c1;
    logic [CW-1:0]   out_c2;
    logic            out_gap1;
    logic            out_gap2;
    logic            out_last;
    logic            busy;
    logic            done;
    logic            err;
    logic [IW:0]     pair_count;

    nw_traceback #(.LENGTH(L), .CWIDTH(CW), .IWIDTH(IW)) dut (
        .clk(clk), .reset(reset), .start(start), .s1(s1), .s2(s2),
        .dir_rd_en(dir_rd_en), .dir_row(dir_row), .dir_col(dir_col), .dir_rdata(dir_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_c1(out_c1), .out_c2(out_c2),
        .out_gap1(out_gap1), .out_gap2(out_gap2), .out_last(out_last),
        .busy(busy), .done(done), .err(err), .pair_count(pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Direction grid: data valid one cycle after the strobe, reserved code otherwise.
    logic [1:0] dmem [L][L];
    always @(posedge clk) dir_rdata <= dir_rd_en ? dmem[dir_row][dir_col] : 2'b11;

    typedef struct {
        int         dmode;     // 0 all corner, 1 top at (3,3), 2 all left, 3 reserved at (3,3)
        logic [7:0] s1v;
        logic [7:0] s2v;
        int         rmode;     // 0 ready always, 1 ready one cycle in three
        int         exp_pairs;
        logic       exp_err;
        int         exp_done;  // cycles from start edge to done, 0 = not checked
        bit         inject;    // extra start while busy
    } vec_t;

    vec_t       vecs [6];
    logic [6:0] expq [$];
    int         n_cmp;
    int         n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void fill_dirs(input int mode);
        for (int j = 0; j < L; j++)
            for (int k = 0; k < L; k++)
                dmem[j][k] = (mode == 2) ? 2'b10 : 2'b00;
        if (mode == 1) dmem[3][3] = 2'b01;
        if (mode == 3) dmem[3][3] = 2'b11;
    endfunction

    // Reference walk of the grid; pushes {c1, c2, gap1, gap2, last} per pair.
    task automatic build_expected(input logic [7:0] a, input logic [7:0] b);
        int  j;
        int  k;
        bit  stop;
        logic [1:0] c1, c2;
        logic g1, g2;
        j = L - 1; k = L - 1; stop = 0;
        while ((j >= 0 || k >= 0) && !stop) begin
            g1 = 0; g2 = 0;
            if (j < 0) begin
                g1 = 1; c1 = 2'b00; c2 = b[k*2 +: 2]; k--;
            end else if (k < 0) begin
                g2 = 1; c1 = a[j*2 +: 2]; c2 = 2'b00; j--;
            end else if (dmem[j][k] == 2'b00) begin
                c1 = a[j*2 +: 2]; c2 = b[k*2 +: 2]; j--; k--;
            end else if (dmem[j][k] == 2'b01) begin
                g2 = 1; c1 = a[j*2 +: 2]; c2 = 2'b00; j--;
            end else if (dmem[j][k] == 2'b10) begin
                g1 = 1; c1 = 2'b00; c2 = b[k*2 +: 2]; k--;
            end else begin
                stop = 1;
            end
            if (!stop) expq.push_back({c1, c2, g1, g2, (j < 0 && k < 0) ? 1'b1 : 1'b0});
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({out_valid, done, busy, err, dir_rd_en, dir_row, dir_col, pair_count,
                    out_c1, out_c2, out_gap1, out_gap2, out_last});
    endfunction

    task automatic run_vec(input int v);
        vec_t       t;
        int         cyc;
        int         n_got;
        int         done_cyc;
        bit         finished;
        bit         have_hold;
        logic [7:0] held;
        logic [7:0] cur;
        logic       prev_rd;
        logic [6:0] e;
        t = vecs[v];
        fill_dirs(t.dmode);
        expq.delete();
        build_expected(t.s1v, t.s2v);
        s1 = t.s1v; s2 = t.s2v; start = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check($sformatf("v%0d busy_after_start", v), 32'(busy), 32'd1);
        check($sformatf("v%0d err_cleared", v), 32'(err), 32'd0);
        check($sformatf("v%0d count_cleared", v), 32'(pair_count), 32'd0);
        check($sformatf("v%0d first_read", v), 32'({dir_rd_en, dir_row, dir_col}), 32'({1'b1, 2'd3, 2'd3}));
        cyc = 0; n_got = 0; done_cyc = -1; finished = 0; have_hold = 0; prev_rd = 1'b0;
        while (!finished && cyc < 300) begin
            if (cyc > 0 && done) begin
                finished = 1;
                done_cyc = cyc;
            end else begin
                out_ready = (t.rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
                start = (t.inject && cyc == 4) ? 1'b1 : 1'b0;
                if (t.inject && cyc == 4) begin
                    s1 = ~t.s1v; s2 = ~t.s2v;
                end
                cur = {out_valid, out_c1, out_c2, out_gap1, out_gap2, out_last};
                if (have_hold) check($sformatf("v%0d stall_stable", v), 32'(cur), 32'(held));
                have_hold = 0;
                if (out_valid && out_ready) begin
                    n_got++;
                    if (expq.size() == 0) begin
                        check($sformatf("v%0d extra_pair", v), 32'(cur), 32'd0);
                    end else begin
                        e = expq.pop_front();
                        check($sformatf("v%0d pair%0d", v, n_got), 32'(cur[6:0]), 32'(e));
                    end
                end else if (out_valid) begin
                    held = cur;
                    have_hold = 1;
                end
                check($sformatf("v%0d single_read", v), 32'(prev_rd & dir_rd_en), 32'd0);
                prev_rd = dir_rd_en;
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        if (!finished) begin
            n_cmp++; n_fail++;
            $display("FAIL v%0d timeout: no done after %0d cycles, expected done", v, cyc);
        end
        check($sformatf("v%0d pairs_seen", v), 32'(n_got), 32'(t.exp_pairs));
        check($sformatf("v%0d pair_count", v), 32'(pair_count), 32'(t.exp_pairs));
        check($sformatf("v%0d err", v), 32'(err), 32'(t.exp_err));
        check($sformatf("v%0d busy_at_done", v), 32'(busy), 32'd0);
        check($sformatf("v%0d queue_left", v), 32'(expq.size()), 32'd0);
        if (t.exp_done > 0) check($sformatf("v%0d done_latency", v), 32'(done_cyc), 32'(t.exp_done));
        @(posedge clk); #1;
        check($sformatf("v%0d done_one_cycle", v), 32'(done), 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; s1 = 8'h00; s2 = 8'h00;
        fill_dirs(0);
        //          dmode s1     s2     rmode pairs err  done inject
        vecs[0] = '{0, 8'hE4, 8'hE4, 0, 4, 1'b0, 12, 1'b0};
        vecs[1] = '{1, 8'hE4, 8'h1B, 0, 5, 1'b0, 14, 1'b0};
        vecs[2] = '{2, 8'hE4, 8'h1B, 0, 8, 1'b0, 20, 1'b0};
        vecs[3] = '{0, 8'hE4, 8'hE4, 1, 4, 1'b0, 0,  1'b0};
        vecs[4] = '{3, 8'hE4, 8'hE4, 0, 0, 1'b1, 2,  1'b0};
        vecs[5] = '{0, 8'hE4, 8'hE4, 0, 4, 1'b0, 12, 1'b1};
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_outputs", all_outputs(), 32'd0);

        // Abandon an alignment mid-EMIT with a stalled consumer.
        s1 = 8'hE4; s2 = 8'hE4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        check("emit_reached", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_in_emit", all_outputs(), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("no_done_after_reset", 32'({done, busy}), 32'd0);
        end

        for (int v = 0; v < 6; v++) run_vec(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
